core_sequencer: RTL
===================

Name: core_sequencer

Overview:
Multi-cycle instruction sequencer for the RV32E core. It owns the PC and instruction register and steps each instruction through FETCH, EXEC, MEM and WB. It handshakes with the instruction and data memory ports and gates the register-file and memory strobes, using the decoded control signals fed back from the instruction decoder. A wait-timeout watchdog and a PC-misalignment check drive a sticky trap.

Parameters:
RESET_PC, 32'h8000_0000, PC value loaded on reset.
TIMEOUT, 255, max wait cycles for memory ready in FETCH or MEM; 0 disables the watchdog.

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
imem_valid  out  1  fetch request; address is pc
imem_ready  in  1  fetch accepted, imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction
inst  out  32  instruction register, feeds the decoder
pc  out  32  current PC
next_pc  in  32  datapath-computed successor PC (pc+4, branch or jump target)
mem_read  in  1  decoded load
mem_write  in  1  decoded store
reg_write  in  1  decoded register write
dmem_valid  out  1  data request; address and wdata come from the datapath
dmem_wen  out  1  store qualifier, valid only with dmem_valid
dmem_ready  in  1  data access complete
load_we  out  1  one-cycle pulse: datapath latches load data
rf_wen  out  1  register-file write strobe
retire  out  1  one-cycle pulse per completed instruction
trap  out  1  sticky error flag
trap_cause  out  2  0 none, 1 imem timeout, 2 dmem timeout, 3 misaligned next_pc

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low on rst_n.
- Reset (asynchronous, at any time including mid-access): state=FETCH, pc=RESET_PC, inst=0, wait counter=0, trap=0, trap_cause=0.
- Output values during reset: all strobes, valids and pulses are 0. imem_valid is 0 while rst_n=0 and rises in the first cycle after release.
- FETCH:
  - imem_valid=1.
  - When imem_ready=1: inst<=imem_rdata, go to EXEC.
  - Otherwise hold FETCH and increment the wait counter.
- EXEC: one cycle, during which the decoder and ALU settle on inst.
  - If mem_read or mem_write: go to MEM.
  - Otherwise go to WB.
- MEM:
  - dmem_valid=1, dmem_wen=mem_write.
  - When dmem_ready=1: load_we=mem_read in that cycle, then go to WB.
- WB:
  - rf_wen=reg_write.
  - retire=1.
  - pc<=next_pc, then go to FETCH.
- Handshake rules:
  - Once asserted, a valid stays high until its ready is seen. It is never withdrawn except by reset or trap.
  - A transfer occurs on the cycle where valid=1 and ready=1.
  - Ready while valid=0 is ignored.
- Stability: inst changes only on a FETCH transfer; pc changes only in WB.
- Latency with ready tied high:
  - ALU, branch or jump instruction: 3 cycles (FETCH, EXEC, WB).
  - Load or store: 4 cycles.
  - Throughput: one retire per 3 or 4 cycles.
- Watchdog:
  - The counter clears on every state change.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT while still waiting, go to TRAP with cause 1 (FETCH) or 2 (MEM).
  - Ready arriving in the same cycle the counter hits TIMEOUT wins: the transfer completes and there is no trap.
  - Counter width is clog2(TIMEOUT+1) bits and it saturates (never wraps).
- Misalignment: in WB, if next_pc[1:0]!=0, then:
  - pc is not updated;
  - rf_wen and retire still fire;
  - the sequencer goes to TRAP with cause 3.
- TRAP:
  - Absorbing state; only reset leaves it.
  - trap=1, cause held.
  - All valids, strobes and pulses are 0.
- Decoded inputs are sampled only in EXEC, MEM and WB; their values in other states are don't-care.

Decomposition:
- Shared package holds:
  - state enumeration (FETCH, EXEC, MEM, WB, TRAP);
  - trap cause constants;
  - RESET_PC default.
- One natural sub-module, wait_timer, contains:
  - the saturating counter, with clear and enable inputs;
  - the TIMEOUT compare;
  - the TIMEOUT=0 disable.

Test Plan:
- ADDI with ready tied high: retire at cycle 3 after reset release, rf_wen=1 in WB, pc 0x80000000 -> 0x80000004.
- LW with dmem_ready delayed 5 cycles: dmem_valid held 5 cycles, load_we pulses once, retire after 8 cycles total.
- SW: dmem_wen=1 with dmem_valid, rf_wen=0 in WB, single retire.
- imem_ready never asserted, TIMEOUT=4: trap=1, trap_cause=1 after the 4th wait cycle, imem_valid drops to 0.
- JAL with next_pc=0x80000102: retire=1, pc stays 0x80000000, trap_cause=3.
- rst_n pulsed low during MEM wait: dmem_valid drops immediately, pc=RESET_PC, fetch restarts the cycle after release.

Source files
------------

// File: rtl/core_sequencer_pkg.sv
// Shared types and constants for the RV32E multi-cycle sequencer.
package core_sequencer_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned CAUSE_W  = 2;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

   typedef enum logic [2:0] {
      ST_FETCH = 3'd0,
      ST_EXEC  = 3'd1,
      ST_MEM   = 3'd2,
      ST_WB    = 3'd3,
      ST_TRAP  = 3'd4
   } seq_state_e;

   localparam logic [CAUSE_W-1:0] CAUSE_NONE     = 2'd0;
   localparam logic [CAUSE_W-1:0] CAUSE_IMEM_TO  = 2'd1;
   localparam logic [CAUSE_W-1:0] CAUSE_DMEM_TO  = 2'd2;
   localparam logic [CAUSE_W-1:0] CAUSE_MISALIGN = 2'd3;

endpackage

// File: rtl/core_sequencer_wait_timer.sv
// Saturating wait-cycle counter with timeout detect.
//   clk, rst_n : clock, async active-low reset
//   i_clr      : clear counter (state change)
//   i_en       : a wait cycle is in progress (valid high, ready low)
//   o_expire_c : this wait cycle is the TIMEOUT-th one; 0 when TIMEOUT=0
module core_sequencer_wait_timer #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire_c
);

   localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);
   localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

   logic [CW-1:0] r_cnt;

   // Counter holds the number of completed wait cycles in the current state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt < SAT)) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   // Expire when this wait would bring the count to TIMEOUT; a ready in
   // the same cycle drops i_en, so the transfer wins.
   assign o_expire_c = (TIMEOUT != 0) && i_en && (r_cnt >= LAST);

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/WB sequencer owning PC and IR, with
// memory-wait watchdog and misaligned-PC trap.
//   imem_valid/ready/rdata : instruction fetch handshake, address = pc
//   inst, pc               : instruction register and program counter
//   next_pc                : successor PC from the datapath
//   mem_read/write, reg_write : decoded controls from the decoder
//   dmem_valid/wen/ready   : data access handshake
//   load_we, rf_wen, retire: datapath strobes
//   trap, trap_cause       : sticky error and its reason
module core_sequencer
   import core_sequencer_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned     TIMEOUT  = 255
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_valid,
   input  logic               imem_ready,
   input  logic [XLEN-1:0]    imem_rdata,
   output logic [XLEN-1:0]    inst,
   output logic [XLEN-1:0]    pc,
   input  logic [XLEN-1:0]    next_pc,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic               reg_write,
   output logic               dmem_valid,
   output logic               dmem_wen,
   input  logic               dmem_ready,
   output logic               load_we,
   output logic               rf_wen,
   output logic               retire,
   output logic               trap,
   output logic [CAUSE_W-1:0] trap_cause
);

   seq_state_e         r_state;
   seq_state_e         w_state_nxt;
   logic [XLEN-1:0]    r_pc;
   logic [XLEN-1:0]    r_inst;
   logic [CAUSE_W-1:0] r_cause;

   logic               w_imem_valid;
   logic               w_dmem_valid;
   logic               w_dmem_wen;
   logic               w_load_we;
   logic               w_rf_wen;
   logic               w_retire;
   logic               w_inst_load;
   logic               w_pc_load;
   logic               w_cause_set;
   logic [CAUSE_W-1:0] w_cause_val;
   logic               w_wait;
   logic               w_expire;

   // A wait cycle: request outstanding with no ready.
   assign w_wait = ((r_state == ST_FETCH) && !imem_ready) ||
                   ((r_state == ST_MEM)   && !dmem_ready);

   core_sequencer_wait_timer #(
      .TIMEOUT    (TIMEOUT)
   ) u_wait_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (w_state_nxt != r_state),
      .i_en       (w_wait),
      .o_expire_c (w_expire)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and strobe decode.
   always_comb begin
      w_state_nxt  = r_state;
      w_imem_valid = 1'b0;
      w_dmem_valid = 1'b0;
      w_dmem_wen   = 1'b0;
      w_load_we    = 1'b0;
      w_rf_wen     = 1'b0;
      w_retire     = 1'b0;
      w_inst_load  = 1'b0;
      w_pc_load    = 1'b0;
      w_cause_set  = 1'b0;
      w_cause_val  = CAUSE_NONE;
      case (r_state)
         ST_FETCH: begin
            w_imem_valid = 1'b1;
            if (imem_ready) begin
               w_inst_load = 1'b1;
               w_state_nxt = ST_EXEC;
            end else if (w_expire) begin
               w_cause_set = 1'b1;
               w_cause_val = CAUSE_IMEM_TO;
               w_state_nxt = ST_TRAP;
            end
         end
         ST_EXEC: begin
            w_state_nxt = (mem_read || mem_write) ? ST_MEM : ST_WB;
         end
         ST_MEM: begin
            w_dmem_valid = 1'b1;
            w_dmem_wen   = mem_write;
            if (dmem_ready) begin
               w_load_we   = mem_read;
               w_state_nxt = ST_WB;
            end else if (w_expire) begin
               w_cause_set = 1'b1;
               w_cause_val = CAUSE_DMEM_TO;
               w_state_nxt = ST_TRAP;
            end
         end
         ST_WB: begin
            w_rf_wen = reg_write;
            w_retire = 1'b1;
            // Misaligned successor still retires but freezes the PC.
            if (next_pc[1:0] != 2'b00) begin
               w_cause_set = 1'b1;
               w_cause_val = CAUSE_MISALIGN;
               w_state_nxt = ST_TRAP;
            end else begin
               w_pc_load   = 1'b1;
               w_state_nxt = ST_FETCH;
            end
         end
         ST_TRAP: begin
            w_state_nxt = ST_TRAP;
         end
         default: begin
            w_state_nxt = ST_TRAP;
         end
      endcase
   end

   // PC, instruction register and trap cause.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc    <= RESET_PC;
         r_inst  <= '0;
         r_cause <= CAUSE_NONE;
      end else begin
         if (w_pc_load)   r_pc    <= next_pc;
         if (w_inst_load) r_inst  <= imem_rdata;
         if (w_cause_set) r_cause <= w_cause_val;
      end
   end

   // Reset parks the FSM in FETCH, so the fetch request is masked by rst_n.
   assign imem_valid = w_imem_valid & rst_n;
   assign dmem_valid = w_dmem_valid;
   assign dmem_wen   = w_dmem_wen;
   assign load_we    = w_load_we;
   assign rf_wen     = w_rf_wen;
   assign retire     = w_retire;
   assign inst       = r_inst;
   assign pc         = r_pc;
   assign trap       = (r_state == ST_TRAP);
   assign trap_cause = r_cause;

endmodule
